// File: rtl/pwm_pkg.sv
// Shared register map, CTRL bit positions and counting-mode type for the
// multi-channel PWM.
package pwm_pkg;

  localparam int unsigned ADDR_PERIOD = 0;
  localparam int unsigned ADDR_CTRL   = 1;
  localparam int unsigned ADDR_EN     = 2;
  localparam int unsigned ADDR_POL    = 3;
  localparam int unsigned ADDR_DUTY0  = 4;

  localparam int unsigned CTRL_MODE_BIT   = 0;
  localparam int unsigned CTRL_COMMIT_BIT = 1;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

endpackage

// File: rtl/pwm_period_counter.sv
// Shared period counter: edge (0..P) or center (0..P..1) counting, with a
// boundary flag marking the cycle whose successor count is 0.
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] period_i,
  input  pwm_mode_e        mode_i,
  input  logic             restart_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             up_o,
  output logic             boundary_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             up_q, up_d;

  always_comb begin
    cnt_d = '0;
    up_d  = 1'b1;
    if (period_i == '0) begin
      cnt_d = '0;
      up_d  = 1'b1;
    end else if (mode_i == PWM_EDGE) begin
      cnt_d = (cnt_q >= period_i) ? '0 : cnt_q + 1'b1;
      up_d  = 1'b1;
    end else if (up_q) begin
      cnt_d = (cnt_q >= period_i) ? period_i - 1'b1 : cnt_q + 1'b1;
      // P = 1 turns around straight into 0, which is always an up sample
      up_d  = (cnt_q < period_i) || (cnt_d == '0);
    end else begin
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      up_d  = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || restart_i) begin
      cnt_q <= '0;
      up_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      up_q  <= up_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign up_o       = up_q;
  assign boundary_o = (cnt_d == '0);

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM: shadow/active register file with period-boundary commit,
// shared period counter and a two-stage compare/output pipeline.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned ADDR_W = $clog2(NUM_CH + 4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0]  cfg_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              pwm_sync,
  output logic              commit_pending
);

  logic [CNT_W-1:0]  period_sh_q, period_act_q;
  pwm_mode_e         mode_sh_q, mode_act_q;
  logic [NUM_CH-1:0] en_sh_q, en_act_q, pol_sh_q, pol_act_q;
  logic [CNT_W-1:0]  duty_sh_q  [NUM_CH];
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];
  logic              pending_q, pending_d;

  logic [CNT_W-1:0]  cnt;
  logic              cnt_up, boundary, transfer, restart;
  logic              wr_period, wr_ctrl, wr_en, wr_pol, commit_req;

  logic [NUM_CH-1:0] raw_d, raw_q, en1_q, pol1_q, out_d, out_q;
  logic              sync1_q, sync2_q;

  assign wr_period  = cfg_we && (cfg_addr == ADDR_W'(ADDR_PERIOD));
  assign wr_ctrl    = cfg_we && (cfg_addr == ADDR_W'(ADDR_CTRL));
  assign wr_en      = cfg_we && (cfg_addr == ADDR_W'(ADDR_EN));
  assign wr_pol     = cfg_we && (cfg_addr == ADDR_W'(ADDR_POL));
  assign commit_req = wr_ctrl && cfg_data[CTRL_COMMIT_BIT];

  // pending_q is registered, so a COMMIT landing on a boundary waits a period
  assign transfer  = boundary && pending_q;
  assign restart   = transfer && (mode_sh_q != mode_act_q);
  assign pending_d = transfer ? 1'b0 : (pending_q | commit_req);

  pwm_period_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .period_i   (period_act_q),
    .mode_i     (mode_act_q),
    .restart_i  (restart),
    .cnt_o      (cnt),
    .up_o       (cnt_up),
    .boundary_o (boundary)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      period_sh_q <= '1;
      mode_sh_q   <= PWM_EDGE;
      en_sh_q     <= '0;
      pol_sh_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) duty_sh_q[i] <= '0;
    end else begin
      if (wr_period) period_sh_q <= cfg_data;
      if (wr_ctrl)   mode_sh_q   <= cfg_data[CTRL_MODE_BIT] ? PWM_CENTER : PWM_EDGE;
      if (wr_en)     en_sh_q     <= cfg_data[NUM_CH-1:0];
      if (wr_pol)    pol_sh_q    <= cfg_data[NUM_CH-1:0];
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cfg_we && (cfg_addr == ADDR_W'(ADDR_DUTY0 + i))) duty_sh_q[i] <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_act_q <= '1;
      mode_act_q   <= PWM_EDGE;
      en_act_q     <= '0;
      pol_act_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) duty_act_q[i] <= '0;
      pending_q    <= 1'b0;
    end else begin
      if (transfer) begin
        period_act_q <= period_sh_q;
        mode_act_q   <= mode_sh_q;
        en_act_q     <= en_sh_q;
        pol_act_q    <= pol_sh_q;
        for (int unsigned i = 0; i < NUM_CH; i++) duty_act_q[i] <= duty_sh_q[i];
      end
      pending_q <= pending_d;
    end
  end

  always_comb begin
    raw_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) raw_d[i] = (cnt < duty_act_q[i]);
    out_d = ((raw_q ^ pol1_q) & en1_q) | (pol1_q & ~en1_q);
  end

  // en/pol travel with the compare so a commit hits outputs on a clean sample
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q   <= '0;
      en1_q   <= '0;
      pol1_q  <= '0;
      sync1_q <= 1'b0;
      out_q   <= '0;
      sync2_q <= 1'b0;
    end else begin
      raw_q   <= raw_d;
      en1_q   <= en_act_q;
      pol1_q  <= pol_act_q;
      sync1_q <= (cnt == '0) && cnt_up;
      out_q   <= out_d;
      sync2_q <= sync1_q;
    end
  end

  assign pwm_out        = out_q;
  assign pwm_sync       = sync2_q;
  assign commit_pending = pending_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel with hand-derived sync-aligned
// output patterns.
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ADDR_W = $clog2(NUM_CH + 4);
  localparam int          LIMIT  = 600;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CNT_W-1:0]  cfg_data;
  logic [NUM_CH-1:0] pwm_out;
  logic              pwm_sync;
  logic              commit_pending;

  int n_checks = 0;
  int n_errors = 0;

  pwm_multi_channel #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .pwm_out        (pwm_out),
    .pwm_sync       (pwm_sync),
    .commit_pending (commit_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input int unsigned addr, input int unsigned data);
    @(posedge clk);
    #1;
    cfg_we   = 1'b1;
    cfg_addr = ADDR_W'(addr);
    cfg_data = CNT_W'(data);
    @(posedge clk);
    #1;
    cfg_we   = 1'b0;
  endtask

  task automatic wait_pending_clear();
    int n = 0;
    while (commit_pending && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (commit_pending) check("pending_timeout", 32'(commit_pending), 32'd0);
  endtask

  // counts negedges up to and including the first one showing pwm_sync
  task automatic wait_sync(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pwm_sync && n < LIMIT);
    if (!pwm_sync) check("sync_timeout", 32'(pwm_sync), 32'd1);
  endtask

  initial begin
    int   n;
    logic e;
    logic [7:0] cpat;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cpat = 8'b1000_0011;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", 32'(pwm_out), 32'd0);
    check("rst_sync", 32'(pwm_sync), 32'd0);
    check("rst_pend", 32'(commit_pending), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // edge mode, P=9, duty 3 on channel 0
    wr(ADDR_PERIOD, 9);
    wr(ADDR_DUTY0, 3);
    wr(ADDR_EN, 1);
    wr(ADDR_CTRL, 2);
    check("t1_pend_rise", 32'(commit_pending), 32'd1);
    wait_pending_clear();
    wait_sync(n);
    check("t1_latency", 32'(n), 32'd2);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      check("t1_out", 32'(pwm_out), 32'((k % 10) < 3));
      check("t1_sync", 32'(pwm_sync), 32'((k % 10) == 0));
    end

    // center mode, P=4, duty 2 on channel 1 only
    wr(ADDR_PERIOD, 4);
    wr(ADDR_DUTY0 + 1, 2);
    wr(ADDR_EN, 2);
    wr(ADDR_CTRL, 3);
    wait_pending_clear();
    wait_sync(n);
    check("t2_latency", 32'(n), 32'd2);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      e = cpat[k % 8];
      check("t2_out", 32'(pwm_out), {29'd0, 1'b0, e, 1'b0});
      check("t2_sync", 32'(pwm_sync), 32'((k % 8) == 0));
    end

    // duty extremes and disabled-with-polarity, edge mode P=5
    wr(ADDR_PERIOD, 5);
    wr(ADDR_DUTY0, 0);
    wr(ADDR_DUTY0 + 1, 6);
    wr(ADDR_EN, 3);
    wr(ADDR_POL, 4);
    wr(ADDR_CTRL, 2);
    wait_pending_clear();
    wait_sync(n);
    check("t3_latency", 32'(n), 32'd2);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      check("t3_out", 32'(pwm_out), 32'b110);
      check("t3_sync", 32'(pwm_sync), 32'((k % 6) == 0));
    end

    // shadow atomicity: P=9, duty 3, then duty 8 staged mid-period
    wr(ADDR_PERIOD, 9);
    wr(ADDR_DUTY0, 3);
    wr(ADDR_EN, 1);
    wr(ADDR_POL, 0);
    wr(ADDR_CTRL, 2);
    wait_pending_clear();
    wait_sync(n);
    check("t4_latency", 32'(n), 32'd2);
    wr(ADDR_DUTY0, 8);
    for (int j = 2; j < 20; j++) begin
      @(negedge clk);
      check("t4_hold_out", 32'(pwm_out), 32'((j % 10) < 3));
      check("t4_hold_pend", 32'(commit_pending), 32'd0);
    end
    wait_sync(n);
    check("t4_period", 32'(n), 32'd1);
    wr(ADDR_CTRL, 2);
    for (int j = 2; j < 20; j++) begin
      @(negedge clk);
      e = (j < 10) ? ((j % 10) < 3) : ((j % 10) < 8);
      check("t4_commit_out", 32'(pwm_out), 32'(e));
      check("t4_commit_pend", 32'(commit_pending), 32'(j <= 7));
    end

    // COMMIT sampled on the boundary cycle (cnt = 9) is deferred a period
    wr(ADDR_DUTY0, 3);
    wait_sync(n);
    repeat (6) @(posedge clk);
    wr(ADDR_CTRL, 2);
    for (int j = 8; j < 28; j++) begin
      @(negedge clk);
      e = (j < 20) ? ((j % 10) < 8) : ((j % 10) < 3);
      check("t5_out", 32'(pwm_out), 32'(e));
      check("t5_pend", 32'(commit_pending), 32'(j <= 17));
    end

    // reset mid-period; a POL write presented during reset must be dropped
    wait_sync(n);
    wr(ADDR_CTRL, 2);
    check("t6_pend_pre", 32'(commit_pending), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; cfg_we = 1'b1; cfg_addr = ADDR_W'(ADDR_POL); cfg_data = CNT_W'(7);
    @(posedge clk); #1;
    rst = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    check("t6_out", 32'(pwm_out), 32'd0);
    check("t6_pend", 32'(commit_pending), 32'd0);
    check("t6_sync", 32'(pwm_sync), 32'd0);
    wait_sync(n);
    check("t6_restart", 32'(n), 32'd2);
    wait_sync(n);
    check("t6_period", 32'(n), 32'd256);
    check("t6_out_idle", 32'(pwm_out), 32'd0);
    wr(ADDR_CTRL, 2);
    wait_pending_clear();
    repeat (4) @(negedge clk);
    check("t6_pol_dropped", 32'(pwm_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
